// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed TX line encoder.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } tx_state_e;

  // Line states as {dplus, dminus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // Consecutive data ones after which a zero is stuffed
  localparam int unsigned STUFF_LIMIT  = 6;
  // Bit-times of SE0 at the start of EOP
  localparam int unsigned EOP_SE0_BITS = 2;

  // NRZI toggle between the two differential data states
  function automatic logic [1:0] line_toggle(input logic [1:0] line);
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Rollover counter dividing clk down to USB bit-times; strobes on count 0.
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  localparam int CW = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en_i,
  input  logic clear_i,
  output logic boundary_o
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count 0..CLKS_PER_BIT-1 and wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign boundary_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB full-speed TX line encoder: bit stuffing, NRZI, EOP generation.
//
// Shift-register handshake: shift_enable is a one-cycle request that the
// upstream shift register advance by one bit at the end of this cycle;
// serial_in must hold the current bit whenever shift_enable is high.
// byte_done coincides with the shift_enable that consumes the 8th bit of a
// byte; the next byte must be loaded before the next bit boundary.
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic tx_start,
  input  logic tx_eop_req,
  output logic shift_enable,
  output logic byte_done,
  output logic dplus_out,
  output logic dminus_out,
  output logic tx_busy
);

  localparam logic [2:0] STUFF_CNT = 3'(STUFF_LIMIT);
  localparam logic [2:0] SE0_LAST  = 3'(EOP_SE0_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bit_q, bit_d;       // data bit index in SEND, SE0 bit-time in EOP_SE0
  logic [1:0] line_q, line_d;
  logic       eop_pend_q, eop_pend_d;
  logic       boundary;

  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .en_i      (state_q != IDLE),
    .clear_i   (state_q == IDLE),
    .boundary_o(boundary)
  );

  // Next-state, line and strobe decode; acts only on bit boundaries
  always_comb begin
    state_d      = state_q;
    ones_d       = ones_q;
    bit_d        = bit_q;
    line_d       = line_q;
    eop_pend_d   = eop_pend_q;
    shift_enable = 1'b0;
    byte_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        line_d = LINE_J;
        if (tx_start) begin
          state_d    = SEND;
          ones_d     = '0;
          bit_d      = '0;
          eop_pend_d = 1'b0;
        end
      end
      SEND: begin
        if (boundary) begin
          if (ones_q == STUFF_CNT) begin
            // Stuffed zero: toggle without consuming a data bit
            line_d = line_toggle(line_q);
            ones_d = '0;
          end else if (eop_pend_q) begin
            line_d     = LINE_SE0;
            state_d    = EOP_SE0;
            bit_d      = '0;
            eop_pend_d = 1'b0;
          end else begin
            shift_enable = 1'b1;
            bit_d        = bit_q + 3'd1;
            if (serial_in) begin
              ones_d = ones_q + 3'd1;
            end else begin
              ones_d = '0;
              line_d = line_toggle(line_q);
            end
            if (bit_q == 3'd7) begin
              byte_done = 1'b1;
              if (tx_eop_req) eop_pend_d = 1'b1;
            end
          end
        end
      end
      EOP_SE0: begin
        if (boundary) begin
          if (bit_q == SE0_LAST) begin
            line_d  = LINE_J;
            state_d = EOP_J;
            bit_d   = '0;
          end else begin
            line_d = LINE_SE0;
            bit_d  = bit_q + 3'd1;
          end
        end
      end
      EOP_J: begin
        if (boundary) begin
          line_d  = LINE_J;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered line drivers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      ones_q     <= '0;
      bit_q      <= '0;
      line_q     <= LINE_J;
      eop_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      bit_q      <= bit_d;
      line_q     <= line_d;
      eop_pend_q <= eop_pend_d;
    end
  end

  assign dplus_out  = line_q[1];
  assign dminus_out = line_q[0];
  assign tx_busy    = (state_q != IDLE);

endmodule
